// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM unified-memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } gnt_e;

  localparam int PERF_W = 32;

endpackage

// File: rtl/memarb_perf_cnt.sv
// One gated, wrapping event counter; with EN=0 it collapses to a constant zero.
module memarb_perf_cnt #(
  parameter bit EN = 1'b1,
  parameter int W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  generate
    if (EN) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (inc) cnt <= cnt + W'(1);
      end
    end else begin : g_tie
      logic unused_in;
      assign unused_in = clk ^ rst ^ inc;
      assign cnt       = '0;
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and data, data first with a fetch
// anti-starvation limit. Stall counters are built only when MEMARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_kill_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [31:0]       perf_if_stall_o,
  output logic [31:0]       perf_dm_stall_o
);

  localparam int            SW         = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  state_e        state_q, state_d;
  gnt_e          gnt;
  logic [SW-1:0] streak_q;
  logic          kill_q;
  logic          ack;

  assign ack = (state_q != IDLE) && mem_ack_i;

  always_comb begin
    state_d = state_q;
    gnt     = GNT_NONE;
    case (state_q)
      IDLE: begin
        // A forced fetch that is being killed this cycle leaves the port idle.
        if (dm_req_i && !(if_req_i && streak_q == STREAK_MAX)) gnt = GNT_DM;
        else if (if_req_i && !if_kill_i)                        gnt = GNT_IF;
        if (gnt == GNT_DM)      state_d = DM_BUSY;
        else if (gnt == GNT_IF) state_d = IF_BUSY;
      end
      IF_BUSY, DM_BUSY: if (mem_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      streak_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!if_req_i || gnt == GNT_IF)                 streak_q <= '0;
      else if (gnt == GNT_DM && streak_q != STREAK_MAX) streak_q <= streak_q + SW'(1);
      if (state_q == IF_BUSY) begin
        if (mem_ack_i)      kill_q <= 1'b0;
        else if (if_kill_i) kill_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (gnt == GNT_DM) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= dm_we_i;
      mem_addr_o  <= dm_addr_i;
      mem_wdata_o <= dm_wdata_i;
    end else if (gnt == GNT_IF) begin
      mem_req_o  <= 1'b1;
      mem_we_o   <= 1'b0;
      mem_addr_o <= if_addr_i;
    end else if (ack) begin
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_ready_o <= 1'b0;
      dm_ready_o <= 1'b0;
      if_rdata_o <= '0;
      dm_rdata_o <= '0;
    end else begin
      if_ready_o <= 1'b0;
      dm_ready_o <= 1'b0;
      if (ack && state_q == DM_BUSY) begin
        dm_ready_o <= 1'b1;
        if (!mem_we_o) dm_rdata_o <= mem_rdata_i;
      end
      // A flushed fetch still finishes on the bus but is never delivered.
      if (ack && state_q == IF_BUSY && !kill_q && !if_kill_i) begin
        if_ready_o <= 1'b1;
        if_rdata_o <= mem_rdata_i;
      end
    end
  end

`ifdef MEMARB_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  memarb_perf_cnt #(.EN(PERF_EN), .W(PERF_W)) u_if_stall (
    .clk (clk_i),
    .rst (rst_i),
    .inc (if_req_i & ~if_ready_o),
    .cnt (perf_if_stall_o)
  );

  memarb_perf_cnt #(.EN(PERF_EN), .W(PERF_W)) u_dm_stall (
    .clk (clk_i),
    .rst (rst_i),
    .inc (dm_req_i & ~dm_ready_o),
    .cnt (perf_dm_stall_o)
  );

endmodule
